seg_scan_capture: RTL and testbench

Receive side of the multiplexed 4-digit seven-segment display interface. It samples the active-low anode and segment lines produced by the display scan driver and reconstructs the four displayed hex digits, per-digit decimal points and a frame-valid indication. It sits beside the display driver as a self-check and monitor block, whether on-chip loopback or pin capture. Its outputs feed the register and LED debug path.

---
 rtl/seg_pkg.sv | 38 +++
 rtl/seg_glyph_dec.sv | 38 +++
 rtl/seg_scan_capture.sv | 199 +++++++++++++++++++
 tb/tb_seg_scan_capture.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan capture path.
// Holds the 16 active-low hex glyphs ({g,f,e,d,c,b,a}), the one-hot-low
// anode codes (the same table the scan driver uses to select digits) and
// the capture state machine encoding.
package seg_pkg;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  // Anode codes: a single low bit selects digit i.
  localparam logic [3:0] AN_DIGIT0 = 4'b1110;
  localparam logic [3:0] AN_DIGIT1 = 4'b1101;
  localparam logic [3:0] AN_DIGIT2 = 4'b1011;
  localparam logic [3:0] AN_DIGIT3 = 4'b0111;
  localparam logic [3:0] AN_BLANK  = 4'b1111;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    RUN     = 2'd1,
    STALE   = 2'd2
  } cap_state_e;

endpackage

// File: rtl/seg_glyph_dec.sv
// Combinational seven-segment glyph decoder.
// Ports:
//   seg   in  [6:0] active-low segment pattern {g,f,e,d,c,b,a}
//   value out [3:0] hex value of the glyph, 0 when not a hex glyph
//   known out       1 when seg matched one of the 16 hex glyphs
module seg_glyph_dec
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       known
);

  always_comb begin
    value = 4'h0;
    known = 1'b1;
    case (seg)
      GLYPH_0: value = 4'h0;
      GLYPH_1: value = 4'h1;
      GLYPH_2: value = 4'h2;
      GLYPH_3: value = 4'h3;
      GLYPH_4: value = 4'h4;
      GLYPH_5: value = 4'h5;
      GLYPH_6: value = 4'h6;
      GLYPH_7: value = 4'h7;
      GLYPH_8: value = 4'h8;
      GLYPH_9: value = 4'h9;
      GLYPH_A: value = 4'hA;
      GLYPH_B: value = 4'hB;
      GLYPH_C: value = 4'hC;
      GLYPH_D: value = 4'hD;
      GLYPH_E: value = 4'hE;
      GLYPH_F: value = 4'hF;
      default: known = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of a multiplexed 4-digit seven-segment display.
// Samples the active-low anode/segment/dp lines, waits for each pattern to
// settle, and rebuilds the displayed hex digits, decimal points and a
// frame-valid indication with a staleness timeout.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   an[3:0]         anode lines, active-low (an[i]=0 selects digit i)
//   seg[6:0]        segment lines, active-low {g,f,e,d,c,b,a}
//   dp              decimal point, active-low
//   digits[15:0]    captured digits, digits[4i+3:4i] is digit i
//   dps[3:0]        captured decimal points, active-high
//   unknown[3:0]    last capture for digit i was not a hex glyph
//   frame_stb       pulse when all four digits captured since last pulse
//   frame_valid     high in RUN (after first frame, until timeout)
//   illegal_an      pulse on a stable sample with two or more anodes low
//   timeout         high in STALE
// Handshake: none; every output is a registered level or a one-cycle pulse.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  input  logic        dp,
  output logic [15:0] digits,
  output logic [3:0]  dps,
  output logic [3:0]  unknown,
  output logic        frame_stb,
  output logic        frame_valid,
  output logic        illegal_an,
  output logic        timeout
);

  localparam logic [7:0]  STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [31:0] TIMEOUT_MAX = 32'(TIMEOUT_CYCLES);

  // Synchronizer, packed as {an, seg, dp}; resets to the idle/blank level.
  logic [11:0] sync1_q, sync1_d;
  logic [11:0] sync2_q, sync2_d;

  logic [7:0]  stab_cnt_q, stab_cnt_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  dps_q, dps_d;
  logic [3:0]  unknown_q, unknown_d;
  logic [3:0]  seen_q, seen_d;
  logic        frame_stb_q, frame_stb_d;
  logic        illegal_an_q, illegal_an_d;
  logic        frame_valid_q, frame_valid_d;
  logic        timeout_q, timeout_d;
  cap_state_e  state_q, state_d;

  logic [3:0]  smp_an;
  logic [6:0]  smp_seg;
  logic        smp_dp;
  logic        capture;
  logic        one_low;
  logic        blank;
  logic [1:0]  digit_idx;
  logic [3:0]  digit_bit;
  logic        wr;
  logic [3:0]  seen_set;
  logic [3:0]  dec_value;
  logic        dec_known;

  assign smp_an  = sync2_q[11:8];
  assign smp_seg = sync2_q[7:1];
  assign smp_dp  = sync2_q[0];

  seg_glyph_dec u_dec (
    .seg   (smp_seg),
    .value (dec_value),
    .known (dec_known)
  );

  // Synchronizer and stability counter. The counter is compared against the
  // next sample (stage 1), so it reads 0 in the first cycle a new sample is
  // present and capture lands STABLE_CYCLES cycles later. Capture fires only
  // on the increment into STABLE_MAX, so a held pattern fires once.
  always_comb begin
    sync1_d    = {an, seg, dp};
    sync2_d    = sync1_q;
    stab_cnt_d = stab_cnt_q;
    capture    = 1'b0;
    if (sync1_q != sync2_q) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != STABLE_MAX) begin
      stab_cnt_d = stab_cnt_q + 8'd1;
      capture    = (stab_cnt_q == STABLE_MAX - 8'd1);
    end
  end

  // Anode classification of the stable sample.
  always_comb begin
    one_low   = 1'b1;
    digit_idx = 2'd0;
    case (smp_an)
      AN_DIGIT0: digit_idx = 2'd0;
      AN_DIGIT1: digit_idx = 2'd1;
      AN_DIGIT2: digit_idx = 2'd2;
      AN_DIGIT3: digit_idx = 2'd3;
      default:   one_low   = 1'b0;
    endcase
    blank     = (smp_an == AN_BLANK);
    digit_bit = 4'b0001 << digit_idx;
  end

  assign wr = capture & one_low;

  // Digit registers, frame assembly, timeout counter and state machine.
  always_comb begin
    digits_d     = digits_q;
    dps_d        = dps_q;
    unknown_d    = unknown_q;
    seen_d       = seen_q;
    seen_set     = seen_q | digit_bit;
    frame_stb_d  = 1'b0;
    illegal_an_d = capture & ~one_low & ~blank;
    state_d      = state_q;

    if (wr) begin
      digits_d[{digit_idx, 2'b00} +: 4] = dec_value;
      dps_d[digit_idx]                  = ~smp_dp;
      unknown_d[digit_idx]              = ~dec_known;
      if (state_q == STALE) begin
        // Leaving STALE: discard any partial frame, start from this digit.
        seen_d = digit_bit;
      end else if (seen_set == 4'b1111) begin
        frame_stb_d = 1'b1;
        seen_d      = '0;
      end else begin
        seen_d = seen_set;
      end
    end

    if (wr) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TIMEOUT_MAX) begin
      tmo_cnt_d = tmo_cnt_q;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
    end

    case (state_q)
      ACQUIRE: if (frame_stb_q) state_d = RUN;
      RUN:     if (!wr && tmo_cnt_q == TIMEOUT_MAX) state_d = STALE;
      STALE:   if (wr) state_d = ACQUIRE;
      default: state_d = ACQUIRE;
    endcase

    frame_valid_d = (state_d == RUN);
    timeout_d     = (state_d == STALE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '1;
      sync2_q       <= '1;
      stab_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      digits_q      <= '0;
      dps_q         <= '0;
      unknown_q     <= '0;
      seen_q        <= '0;
      frame_stb_q   <= 1'b0;
      illegal_an_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      state_q       <= ACQUIRE;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stab_cnt_q    <= stab_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      digits_q      <= digits_d;
      dps_q         <= dps_d;
      unknown_q     <= unknown_d;
      seen_q        <= seen_d;
      frame_stb_q   <= frame_stb_d;
      illegal_an_q  <= illegal_an_d;
      frame_valid_q <= frame_valid_d;
      timeout_q     <= timeout_d;
      state_q       <= state_d;
    end
  end

  assign digits      = digits_q;
  assign dps         = dps_q;
  assign unknown     = unknown_q;
  assign frame_stb   = frame_stb_q;
  assign frame_valid = frame_valid_q;
  assign illegal_an  = illegal_an_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed scenarios plus randomized scan
// traffic, every cycle compared against a behavioural model that works from
// input run lengths and edge numbers.
module tb_seg_scan_capture;

  localparam int STABLE = 4;
  localparam int TMO    = 16;
  localparam int M_ACQ   = 0;
  localparam int M_RUN   = 1;
  localparam int M_STALE = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  an = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic        dp = 1'b1;
  logic [15:0] digits;
  logic [3:0]  dps;
  logic [3:0]  unknown;
  logic        frame_stb;
  logic        frame_valid;
  logic        illegal_an;
  logic        timeout;

  always #5 clk = ~clk;

  seg_scan_capture #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .digits      (digits),
    .dps         (dps),
    .unknown     (unknown),
    .frame_stb   (frame_stb),
    .frame_valid (frame_valid),
    .illegal_an  (illegal_an),
    .timeout     (timeout)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic [3:0]  m_dig [4];
  bit          m_dp [4];
  bit          m_unk [4];
  bit          m_seen [4];
  bit          m_stb, m_ill;
  int          m_state;
  int          cyc = 0;
  int          last_w;
  logic [11:0] last_in;
  int          run_len;
  bit          pend;
  logic [11:0] pend_val;
  int          dut_stb_n = 0;
  int          dut_ill_n = 0;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_dig[i] = 4'h0; m_dp[i] = 1'b0; m_unk[i] = 1'b0; m_seen[i] = 1'b0;
    end
    m_stb = 1'b0; m_ill = 1'b0; m_state = M_ACQ;
    last_w = cyc; last_in = 12'hFFF; run_len = 1; pend = 1'b0; pend_val = 12'hFFF;
  endtask

  // One rising edge. A pattern whose input run reaches STABLE+1 equal edges
  // is captured on the following edge.
  task automatic model_edge(input logic [11:0] in_now);
    bit         prev_stb, wr, found;
    int         zeros, idx;
    logic [3:0] a, val;
    cyc++;
    prev_stb = m_stb;
    m_stb = 1'b0; m_ill = 1'b0; wr = 1'b0;
    if (pend) begin
      a = pend_val[11:8];
      zeros = 4 - $countones(a);
      if (zeros == 1) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
        found = 1'b0; val = 4'h0;
        for (int k = 0; k < 16; k++)
          if (glyph_tab[k] == pend_val[7:1]) begin found = 1'b1; val = 4'(k); end
        wr = 1'b1;
        m_dig[idx] = val; m_dp[idx] = !pend_val[0]; m_unk[idx] = !found;
        if (m_state == M_STALE) begin
          for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
          m_seen[idx] = 1'b1;
        end else begin
          m_seen[idx] = 1'b1;
          if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
            m_stb = 1'b1;
            for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
          end
        end
      end else if (zeros >= 2) begin
        m_ill = 1'b1;
      end
    end
    case (m_state)
      M_ACQ:   if (prev_stb) m_state = M_RUN;
      M_RUN:   if (!wr && (cyc - 1 - last_w) >= TMO) m_state = M_STALE;
      default: if (wr) m_state = M_ACQ;
    endcase
    if (wr) last_w = cyc;
    if (in_now == last_in) run_len++; else run_len = 1;
    last_in  = in_now;
    pend     = (run_len == STABLE + 1);
    pend_val = in_now;
  endtask

  task automatic compare_all();
    logic [15:0] md;
    logic [3:0]  mdp, munk;
    for (int i = 0; i < 4; i++) begin
      md[4*i +: 4] = m_dig[i]; mdp[i] = m_dp[i]; munk[i] = m_unk[i];
    end
    check("digits",      32'(digits),      32'(md));
    check("dps",         32'(dps),         32'(mdp));
    check("unknown",     32'(unknown),     32'(munk));
    check("frame_stb",   32'(frame_stb),   32'(m_stb));
    check("illegal_an",  32'(illegal_an),  32'(m_ill));
    check("frame_valid", 32'(frame_valid), 32'(m_state == M_RUN));
    check("timeout",     32'(timeout),     32'(m_state == M_STALE));
    if (frame_stb)  dut_stb_n++;
    if (illegal_an) dut_ill_n++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [3:0] a, input logic [6:0] s, input logic d);
    an = a; seg = s; dp = d;
    @(posedge clk);
    model_edge({a, s, d});
    #1 compare_all();
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
    for (int i = 0; i < n; i++) step(a, s, d);
  endtask

  function automatic logic [3:0] an_code(input int i);
    logic [3:0] b;
    b = 4'b0001 << i[1:0];
    return ~b;
  endfunction

  task automatic scan_digit(input int i, input int v, input logic d, input int n);
    hold(an_code(i), glyph_tab[v], d, n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; an = 4'hF; seg = 7'h7F; dp = 1'b1;
    model_reset();
    #1;
    check("rst_digits",  32'(digits), 32'h0);
    check("rst_flags",   32'({dps, unknown, frame_stb, frame_valid, illegal_an, timeout}), 32'h0);
    compare_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          s0, i0, n;
    logic [3:0]  a;
    logic [6:0]  s;
    logic [1:0]  ri;

    #1 do_reset();

    // Full frame 1,2,3,4 with dp on digit 2 only.
    s0 = dut_stb_n;
    scan_digit(0, 1, 1'b1, 8);
    scan_digit(1, 2, 1'b1, 8);
    scan_digit(2, 3, 1'b0, 8);
    scan_digit(3, 4, 1'b1, 8);
    check("ff_digits", 32'(digits), 32'h4321);
    check("ff_dps", 32'(dps), 32'h4);
    check("ff_unknown", 32'(unknown), 32'h0);
    check("ff_stb_count", 32'(dut_stb_n - s0), 32'd1);
    check("ff_valid", 32'(frame_valid), 32'd1);

    // Glitch reject: short illegal anode and ghost, then a held illegal one.
    i0 = dut_ill_n;
    scan_digit(0, 5, 1'b1, 8);
    hold(4'b1100, glyph_tab[8], 1'b1, 2);
    hold(4'b1101, glyph_tab[9], 1'b1, 3);
    hold(4'hF, 7'h7F, 1'b1, 2);
    check("gl_no_ill", 32'(dut_ill_n - i0), 32'd0);
    hold(4'b1100, glyph_tab[8], 1'b1, 8);
    check("gl_ghost", 32'(digits[7:4]), 32'h2);
    check("gl_ill_once", 32'(dut_ill_n - i0), 32'd1);

    // Exact latency: capture on the sixth edge of the new pattern.
    hold(4'hF, 7'h7F, 1'b1, 6);
    hold(4'b1110, 7'b0001000, 1'b1, 5);
    check("lat_k4", 32'(digits[3:0]), 32'h5);
    step(4'b1110, 7'b0001000, 1'b1);
    check("lat_k5", 32'(digits[3:0]), 32'hA);

    // Unknown glyph then a valid 7 on digit 1.
    hold(4'b1101, 7'h7F, 1'b1, 8);
    check("unk_val", 32'(digits[7:4]), 32'h0);
    check("unk_flag", 32'(unknown[1]), 32'd1);
    scan_digit(1, 7, 1'b1, 8);
    check("unk_clear", 32'(unknown[1]), 32'd0);
    check("unk_seven", 32'(digits[7:4]), 32'h7);

    // Timeout and recovery.
    for (int i = 0; i < 4; i++) scan_digit(i, 8 + i, 1'b1, 8);
    hold(4'hF, 7'h7F, 1'b1, 2);
    check("to_run", 32'(frame_valid), 32'd1);
    hold(4'hF, 7'h7F, 1'b1, 20);
    check("to_timeout", 32'(timeout), 32'd1);
    check("to_invalid", 32'(frame_valid), 32'd0);
    scan_digit(0, 3, 1'b1, 8);
    check("to_resume_to", 32'(timeout), 32'd0);
    scan_digit(1, 3, 1'b1, 8);
    scan_digit(2, 3, 1'b1, 8);
    check("to_resume_fv", 32'(frame_valid), 32'd0);
    scan_digit(3, 3, 1'b1, 8);
    check("to_rerun", 32'(frame_valid), 32'd1);

    // Reset mid-frame discards the partial frame.
    scan_digit(0, 1, 1'b0, 8);
    scan_digit(1, 2, 1'b0, 8);
    scan_digit(2, 3, 1'b0, 8);
    do_reset();
    s0 = dut_stb_n;
    scan_digit(1, 5, 1'b1, 8);
    scan_digit(2, 6, 1'b1, 8);
    scan_digit(3, 7, 1'b1, 8);
    check("rf_no_stb", 32'(dut_stb_n - s0), 32'd0);
    scan_digit(0, 4, 1'b1, 8);
    check("rf_stb", 32'(dut_stb_n - s0), 32'd1);
    check("rf_digits", 32'(digits), 32'h7654);

    // Randomized scan traffic.
    repeat (400) begin
      n = $urandom_range(0, 9);
      if (n < 6) begin
        ri = 2'($urandom_range(0, 3));
        a = an_code(int'(ri));
        s = ($urandom_range(0, 7) == 0) ? 7'($urandom) : glyph_tab[$urandom_range(0, 15)];
      end else if (n < 8) begin
        a = 4'hF;
        s = 7'($urandom);
      end else begin
        a = 4'($urandom);
        s = glyph_tab[$urandom_range(0, 15)];
      end
      hold(a, s, 1'($urandom_range(0, 1)), $urandom_range(1, 10));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
